pc_sequencer: RTL and testbench
===============================

# pc_sequencer

Next-address controller for the fetch-stage PC register. Each cycle it chooses the PC's next value (sequential increment, branch/jump redirect, exception vector, or hold) and drives the PC's hold input. It defers redirects that arrive during pipeline stalls and manages halt/resume and exception entry. It sits between the IF-stage PC register and the ID/EX hazard and branch logic.

## Interface
- ADDR_W, 16, address width
- RESET_VEC, 16'h0000, first fetch address after reset
- EXC_VEC, 16'h0010, exception handler entry address
- INC, 2, sequential PC increment (bytes per instruction)

- clk  in  1  clock, rising edge
- reset  in  1  asynchronous, active-low reset
- pc_in  in  ADDR_W  current PC register output
- stall  in  1  pipeline stall from hazard unit; hold PC
- redirect_valid  in  1  taken branch or jump this cycle
- redirect_target  in  ADDR_W  branch/jump destination
- exception  in  1  exception request, one-cycle pulse
- halt_req  in  1  enter halted state
- resume  in  1  leave halted state
- next_pc  out  ADDR_W  value loaded by the PC register (its address input)
- pc_halt  out  1  PC register hold; 1 = PC keeps its value
- flush  out  1  one-cycle kill of IF/ID contents
- epc  out  ADDR_W  PC captured at exception entry
- halted  out  1  registered; 1 while in HALT

## Operation
- States: RST, RUN, HALT, EXC.
- next_pc, pc_halt and flush are combinational from state, inputs and the pending register.
- epc, halted, the state and the pending register are registered.

**RST**
- next_pc = RESET_VEC, pc_halt = 0, so the PC loads RESET_VEC.
- Moves to RUN after one cycle.

**RUN** — priority exception > redirect > halt_req > stall > sequential.
- exception:
  - epc <= pc_in.
  - next_pc = EXC_VEC, pc_halt = 0, flush = 1.
  - Pending register cleared; moves to EXC.
  - Overrides stall, redirect and halt_req.
- Live redirect with stall = 0:
  - next_pc = redirect_target, pc_halt = 0, flush = 1.
  - Pending register cleared.
- Live redirect with stall = 1:
  - pend_valid <= 1, pend_target <= redirect_target.
  - pc_halt = 1, flush = 0.
  - A later redirect overwrites the pending target (newest wins).
- Pending redirect with stall = 0 and no live redirect:
  - next_pc = pend_target, flush = 1, pc_halt = 0.
  - pend_valid <= 0.
- Live redirect and pending redirect together with stall = 0: the live one wins and pending is cleared.
- halt_req:
  - pc_halt = 1; moves to HALT.
  - The pending redirect is retained; a redirect arriving in the same cycle is captured into pending.
- stall only: pc_halt = 1, next_pc = pc_in.
- Otherwise:
  - next_pc = (pc_in + INC) mod 2^ADDR_W; 16'hFFFE wraps to 16'h0000 with no flag.
  - pc_halt = 0.

**EXC**
- pc_halt = 1, flush = 0 for one cycle to drain the pipeline.
- redirect_valid is ignored and not captured.
- Moves to RUN.

**HALT**
- pc_halt = 1, halted = 1.
- A redirect is captured into pending.
- resume: moves to RUN. The first RUN cycle applies the pending redirect if present and stall = 0.
- exception: handled exactly as in RUN. epc = pc_in; moves to EXC; halted drops next cycle.
- resume and halt_req together in HALT: resume wins. halt_req then re-enters HALT on the next RUN cycle if it is still asserted.

## Timing
- While reset = 0, regardless of clk:
  - state = RST, halted = 0, epc = 0, pend_valid = 0, pend_target = 0.
  - next_pc = RESET_VEC, pc_halt = 1, flush = 0.
- Reset deasserts before edge E0: the PC loads RESET_VEC at the edge that leaves RST. The first sequential increment follows at the next edge.
- Redirect latency:
  - redirect_valid high in cycle N with no stall: flush high in cycle N, PC = target in cycle N+1.
  - Stalled: the target appears the cycle after stall falls.
- Exception in cycle N:
  - PC = EXC_VEC in N+1 (EXC), still EXC_VEC in N+2.
  - Increments to EXC_VEC+INC in N+3.
- halted rises the cycle after halt_req is accepted and falls the cycle after resume or exception is accepted.
- reset asserted mid-operation: immediate return to reset values; the pending redirect is lost.

## Test plan
- Reset then free-run: reset low 2 cycles, release. PC sequence is 0x0000, 0x0002, 0x0004, 0x0006; flush stays 0.
- Redirect: at PC = 0x0006, redirect_valid = 1 with target 0x0100. flush = 1 that cycle; PC = 0x0100 next, then 0x0102.
- Deferred redirect:
  - stall high 3 cycles at PC = 0x0010; targets 0x0200 then 0x0300 are presented during the stall.
  - PC holds 0x0010 throughout the stall.
  - After stall drops: flush = 1 and PC = 0x0300.
- Exception:
  - exception at PC = 0x0040 with a simultaneous redirect to 0x0500.
  - Required: epc = 0x0040, flush = 1; PC = 0x0010 for 2 cycles, then 0x0012; the redirect is discarded.
- Halt/resume:
  - halt_req at PC = 0x0020; redirect to 0x0400 during HALT.
  - halted = 1 and PC frozen at 0x0020.
  - After resume: flush = 1 and PC = 0x0400.
- Wrap and async reset:
  - Redirect to 0xFFFE; the next PC is 0x0000.
  - Then assert reset mid-stall: outputs take reset values immediately (next_pc = 0x0000, pc_halt = 1, epc = 0, halted = 0) without waiting for clk.

Source files
------------

// File: rtl/pc_sequencer.sv
// Next-address controller for the fetch-stage PC register: chooses sequential,
// redirect, exception-vector or hold each cycle and manages halt/exception entry.
module pc_sequencer #(
    parameter int unsigned            ADDR_W    = 16,
    parameter logic [ADDR_W-1:0]      RESET_VEC = 16'h0000,
    parameter logic [ADDR_W-1:0]      EXC_VEC   = 16'h0010,
    parameter int unsigned            INC       = 2
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [ADDR_W-1:0] pc_in,
    input  logic              stall,
    input  logic              redirect_valid,
    input  logic [ADDR_W-1:0] redirect_target,
    input  logic              exception,
    input  logic              halt_req,
    input  logic              resume,
    output logic [ADDR_W-1:0] next_pc,
    output logic              pc_halt,
    output logic              flush,
    output logic [ADDR_W-1:0] epc,
    output logic              halted
);

    localparam logic [1:0] ST_RST  = 2'd0;
    localparam logic [1:0] ST_RUN  = 2'd1;
    localparam logic [1:0] ST_HALT = 2'd2;
    localparam logic [1:0] ST_EXC  = 2'd3;

    logic [1:0]        state, next_state;
    logic              pend_valid, pend_valid_d;
    logic [ADDR_W-1:0] pend_target, pend_target_d;
    logic [ADDR_W-1:0] epc_d;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state       <= ST_RST;
            pend_valid  <= 1'b0;
            pend_target <= '0;
            epc         <= '0;
            halted      <= 1'b0;
        end else begin
            state       <= next_state;
            pend_valid  <= pend_valid_d;
            pend_target <= pend_target_d;
            epc         <= epc_d;
            halted      <= (next_state == ST_HALT);
        end
    end

    // Next-state, pending-redirect bookkeeping and the combinational PC controls.
    always_comb begin
        next_state    = state;
        pend_valid_d  = pend_valid;
        pend_target_d = pend_target;
        epc_d         = epc;
        next_pc       = pc_in;
        pc_halt       = 1'b1;
        flush         = 1'b0;

        case (state)
            ST_RST: begin
                next_pc    = RESET_VEC;
                pc_halt    = 1'b0;
                next_state = ST_RUN;
            end
            ST_RUN: begin
                if (exception) begin
                    epc_d        = pc_in;
                    next_pc      = EXC_VEC;
                    pc_halt      = 1'b0;
                    flush        = 1'b1;
                    pend_valid_d = 1'b0;
                    next_state   = ST_EXC;
                end else if (redirect_valid && !stall) begin
                    next_pc      = redirect_target;
                    pc_halt      = 1'b0;
                    flush        = 1'b1;
                    pend_valid_d = 1'b0;
                end else if (pend_valid && !stall) begin
                    next_pc      = pend_target;
                    pc_halt      = 1'b0;
                    flush        = 1'b1;
                    pend_valid_d = 1'b0;
                end else if (halt_req) begin
                    if (redirect_valid) begin
                        pend_valid_d  = 1'b1;
                        pend_target_d = redirect_target;
                    end
                    next_state = ST_HALT;
                end else if (redirect_valid) begin
                    // Only reachable with stall high: defer, newest target wins.
                    pend_valid_d  = 1'b1;
                    pend_target_d = redirect_target;
                end else if (!stall) begin
                    next_pc = pc_in + ADDR_W'(INC);
                    pc_halt = 1'b0;
                end
            end
            ST_HALT: begin
                if (exception) begin
                    epc_d        = pc_in;
                    next_pc      = EXC_VEC;
                    pc_halt      = 1'b0;
                    flush        = 1'b1;
                    pend_valid_d = 1'b0;
                    next_state   = ST_EXC;
                end else begin
                    if (redirect_valid) begin
                        pend_valid_d  = 1'b1;
                        pend_target_d = redirect_target;
                    end
                    if (resume) begin
                        next_state = ST_RUN;
                    end
                end
            end
            ST_EXC: begin
                next_state = ST_RUN;
            end
            default: begin
                next_state = ST_RST;
            end
        endcase

        // Reset forces the PC controls immediately, independent of clk.
        if (!reset) begin
            next_pc = RESET_VEC;
            pc_halt = 1'b1;
            flush   = 1'b0;
        end
    end

endmodule

// File: tb/tb_pc_sequencer.sv
// Directed bench for pc_sequencer with a behavioural PC register closing the loop.
module tb_pc_sequencer;

    logic        clk = 1'b0;
    logic        reset;
    logic [15:0] pc = 16'hBEEF;
    logic        stall, redirect_valid, exception, halt_req, resume;
    logic [15:0] redirect_target;
    logic [15:0] next_pc, epc;
    logic        pc_halt, flush, halted;

    int n_tests = 0;
    int n_fail  = 0;

    always #5 clk = ~clk;

    pc_sequencer dut (
        .clk             (clk),
        .reset           (reset),
        .pc_in           (pc),
        .stall           (stall),
        .redirect_valid  (redirect_valid),
        .redirect_target (redirect_target),
        .exception       (exception),
        .halt_req        (halt_req),
        .resume          (resume),
        .next_pc         (next_pc),
        .pc_halt         (pc_halt),
        .flush           (flush),
        .epc             (epc),
        .halted          (halted)
    );

    // PC register driven by the sequencer.
    always @(posedge clk) begin
        if (!pc_halt) pc <= next_pc;
    end

    task automatic check(input string tag, input logic [15:0] got, input logic [15:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%04h, expected 0x%04h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        stall = 0; redirect_valid = 0; redirect_target = 16'h0;
        exception = 0; halt_req = 0; resume = 0;
    endtask

    // Unstalled redirect, then advance one cycle so the PC holds the target.
    task automatic jump(input logic [15:0] tgt);
        redirect_valid = 1; redirect_target = tgt;
        tick();
        redirect_valid = 0;
        #1;
    endtask

    initial begin
        idle_inputs();
        reset = 0;
        tick();
        tick();
        #1;
        check("rst_next_pc", next_pc, 16'h0000);
        check("rst_pc_halt", 16'(pc_halt), 16'h1);
        check("rst_flush", 16'(flush), 16'h0);
        check("rst_halted", 16'(halted), 16'h0);
        check("rst_epc", epc, 16'h0000);

        // Release: RST state loads the reset vector, then free-run.
        reset = 1;
        #1;
        check("rst_state_load", 16'(pc_halt), 16'h0);
        tick(); check("pc0", pc, 16'h0000); check("flush0", 16'(flush), 16'h0);
        tick(); check("pc1", pc, 16'h0002); check("flush1", 16'(flush), 16'h0);
        tick(); check("pc2", pc, 16'h0004);
        tick(); check("pc3", pc, 16'h0006);

        // Redirect.
        redirect_valid = 1; redirect_target = 16'h0100;
        #1;
        check("redir_flush", 16'(flush), 16'h1);
        check("redir_next", next_pc, 16'h0100);
        tick(); redirect_valid = 0; #1;
        check("redir_pc", pc, 16'h0100);
        tick(); check("redir_inc", pc, 16'h0102);

        // Deferred redirect during a 3-cycle stall.
        jump(16'h0010);
        check("pc_0010", pc, 16'h0010);
        stall = 1; redirect_valid = 1; redirect_target = 16'h0200;
        #1; check("stall_hold0", 16'(pc_halt), 16'h1); check("stall_noflush", 16'(flush), 16'h0);
        tick(); check("stall_pc0", pc, 16'h0010);
        redirect_target = 16'h0300;
        tick(); check("stall_pc1", pc, 16'h0010);
        redirect_valid = 0;
        tick(); check("stall_pc2", pc, 16'h0010);
        stall = 0;
        #1;
        check("pend_flush", 16'(flush), 16'h1);
        check("pend_next", next_pc, 16'h0300);
        tick(); check("pend_pc", pc, 16'h0300);
        check("pend_cleared_flush", 16'(flush), 16'h0);

        // Exception with simultaneous redirect.
        jump(16'h0040);
        exception = 1; redirect_valid = 1; redirect_target = 16'h0500;
        #1;
        check("exc_flush", 16'(flush), 16'h1);
        check("exc_next", next_pc, 16'h0010);
        tick(); exception = 0; redirect_valid = 0; #1;
        check("exc_epc", epc, 16'h0040);
        check("exc_pc1", pc, 16'h0010);
        check("exc_drain_hold", 16'(pc_halt), 16'h1);
        tick(); check("exc_pc2", pc, 16'h0010);
        tick(); check("exc_pc3", pc, 16'h0012);

        // Halt with a redirect captured while halted, then resume.
        jump(16'h0020);
        halt_req = 1;
        #1; check("halt_hold", 16'(pc_halt), 16'h1);
        tick(); halt_req = 0; #1;
        check("halted_hi", 16'(halted), 16'h1);
        redirect_valid = 1; redirect_target = 16'h0400;
        tick(); redirect_valid = 0; #1;
        check("halt_pc0", pc, 16'h0020);
        tick();
        check("halt_pc1", pc, 16'h0020);
        check("halted_hold", 16'(halted), 16'h1);
        resume = 1;
        tick(); resume = 0; #1;
        check("halted_lo", 16'(halted), 16'h0);
        check("resume_flush", 16'(flush), 16'h1);
        check("resume_next", next_pc, 16'h0400);
        tick(); check("resume_pc", pc, 16'h0400);

        // Wrap-around.
        jump(16'hFFFE);
        check("pc_fffe", pc, 16'hFFFE);
        check("wrap_next", next_pc, 16'h0000);
        tick(); check("wrap_pc", pc, 16'h0000);

        // Async reset mid-stall with a pending redirect.
        stall = 1; redirect_valid = 1; redirect_target = 16'h0700;
        tick(); redirect_valid = 0;
        #2;
        reset = 0;
        #1;
        check("areset_next", next_pc, 16'h0000);
        check("areset_hold", 16'(pc_halt), 16'h1);
        check("areset_epc", epc, 16'h0000);
        check("areset_halted", 16'(halted), 16'h0);
        check("areset_flush", 16'(flush), 16'h0);
        tick();
        idle_inputs();
        reset = 1;
        tick(); check("rerst_pc", pc, 16'h0000);
        check("pend_lost_flush", 16'(flush), 16'h0);
        check("pend_lost_next", next_pc, 16'h0002);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1);
    end

endmodule
